// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: op_mudi bit positions and sequencer state encoding
package muldiv_ctrl_pkg;
  localparam int MUDI_MULT  = 0;
  localparam int MUDI_MULTU = 1;
  localparam int MUDI_DIV   = 2;
  localparam int MUDI_DIVU  = 3;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;
endpackage

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences divider-core handshakes, stalls EXE, commits HI/LO once per mul/div
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op_mudi,
  input  logic        op_fire,
  input  logic        flush,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [63:0] prod,
  output logic        div_s_tvalid,
  input  logic        div_s_tready,
  output logic        div_u_tvalid,
  input  logic        div_u_tready,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_s_dout_valid,
  input  logic        div_u_dout_valid,
  input  logic [63:0] div_s_dout,
  input  logic [63:0] div_u_dout,
  output logic [1:0]  hl_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        stall,
  output logic        busy
);
  state_t state, state_n;
  logic [31:0] dividend_q, divisor_q;
  logic [1:0]  div_sel_q;
  logic [63:0] dout_q;
  logic is_div, is_mul, start, hs, dv, done_wr, mul_wr;
  assign is_div  = op_mudi[MUDI_DIV] | op_mudi[MUDI_DIVU];
  assign is_mul  = op_mudi[MUDI_MULT] | op_mudi[MUDI_MULTU];
  assign start   = op_valid & is_div & ~flush;
  assign hs      = (state == S_ISSUE) & (div_sel_q[0] ? div_s_tready : div_u_tready);
  // only the core that was actually issued to can end WAIT or DRAIN
  assign dv      = div_sel_q[0] ? div_s_dout_valid : div_u_dout_valid;
  assign done_wr = (state == S_DONE) & op_fire & ~flush;
  assign mul_wr  = op_valid & op_fire & ~flush & is_mul;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = start ? S_ISSUE : S_IDLE;
      S_ISSUE: state_n = hs ? (flush ? S_DRAIN : S_WAIT) : (flush ? S_IDLE : S_ISSUE);
      S_WAIT:  state_n = dv ? (flush ? S_IDLE : S_DONE) : (flush ? S_DRAIN : S_WAIT);
      S_DONE:  state_n = (flush | op_fire) ? S_IDLE : S_DONE;
      S_DRAIN: state_n = dv ? S_IDLE : S_DRAIN;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      dividend_q <= '0;
      divisor_q  <= '0;
      div_sel_q  <= '0;
      dout_q     <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start) begin
        dividend_q <= src1;
        divisor_q  <= src2;
        div_sel_q  <= op_mudi[MUDI_DIVU:MUDI_DIV];
      end
      if (state == S_WAIT && dv)
        dout_q <= div_sel_q[0] ? div_s_dout : div_u_dout;
    end
  end
  assign div_s_tvalid = (state == S_ISSUE) & div_sel_q[0];
  assign div_u_tvalid = (state == S_ISSUE) & div_sel_q[1];
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign hl_we        = {2{done_wr | mul_wr}};
  assign hi_wdata     = done_wr ? dout_q[31:0]  : mul_wr ? prod[63:32] : '0;
  assign lo_wdata     = done_wr ? dout_q[63:32] : mul_wr ? prod[31:0]  : '0;
  assign stall        = start & (state != S_DONE);
  assign busy         = state != S_IDLE;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed checks of muldiv_ctrl against a fixed-latency divider core model
module tb_muldiv_ctrl;
  localparam int LAT = 8;
  logic        clk = 0;
  logic        reset = 1;
  logic        op_valid = 0, op_fire = 0, flush = 0;
  logic [3:0]  op_mudi = 0;
  logic [31:0] src1 = 0, src2 = 0;
  logic [63:0] prod = 0;
  logic        div_s_tvalid, div_u_tvalid;
  logic        div_s_tready = 0, div_u_tready = 0;
  logic [31:0] div_dividend, div_divisor;
  logic        div_s_dout_valid = 0, div_u_dout_valid = 0;
  logic [63:0] div_s_dout = 0, div_u_dout = 0;
  logic [1:0]  hl_we;
  logic [31:0] hi_wdata, lo_wdata;
  logic        stall, busy;
  int errors = 0, checks = 0;
  int cnt = 0, hs_cnt = 0, dv_cnt = 0;
  logic p_sgn = 0;
  logic [63:0] p_dout = 0;

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_mudi(op_mudi), .op_fire(op_fire),
    .flush(flush), .src1(src1), .src2(src2), .prod(prod),
    .div_s_tvalid(div_s_tvalid), .div_s_tready(div_s_tready),
    .div_u_tvalid(div_u_tvalid), .div_u_tready(div_u_tready),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_s_dout_valid(div_s_dout_valid), .div_u_dout_valid(div_u_dout_valid),
    .div_s_dout(div_s_dout), .div_u_dout(div_u_dout),
    .hl_we(hl_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] core(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    q = s ? 32'($signed(a) / $signed(b)) : a / b;
    r = s ? 32'($signed(a) % $signed(b)) : a % b;
    return {q, r};
  endfunction

  // one clock; the divider core model answers LAT cycles after its handshake
  task automatic cyc();
    logic hs_s, hs_u;
    hs_s = div_s_tvalid & div_s_tready;
    hs_u = div_u_tvalid & div_u_tready;
    if (hs_s | hs_u) begin
      hs_cnt++;
      p_sgn  = hs_s;
      p_dout = core(div_dividend, div_divisor, hs_s);
    end
    @(posedge clk);
    #1;
    div_s_dout_valid = 0;
    div_u_dout_valid = 0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        dv_cnt++;
        if (p_sgn) div_s_dout_valid = 1;
        else div_u_dout_valid = 1;
      end
    end
    if (hs_s | hs_u) cnt = LAT - 1;
    div_s_dout = p_dout;
    div_u_dout = p_dout;
  endtask

  task automatic run_div(input string tag, input logic [3:0] mudi, input logic [31:0] a,
                         input logic [31:0] b, input int hold, input int exp_stall,
                         input logic [31:0] ehi, input logic [31:0] elo);
    int n = 0, bad = 0, tv_n = 0, h0 = hs_cnt;
    logic saw_s = 0, saw_u = 0;
    op_valid = 1; op_mudi = mudi; src1 = a; src2 = b; op_fire = 0; flush = 0;
    for (int i = 0; i < 60; i++) begin
      div_s_tready = i > hold;
      div_u_tready = i > hold;
      #1;
      if (!stall) break;
      saw_s |= div_s_tvalid;
      saw_u |= div_u_tvalid;
      if (div_s_tvalid | div_u_tvalid) begin
        tv_n++;
        if (div_dividend != a || div_divisor != b) bad++;
      end
      if (div_s_tvalid & div_u_tvalid) bad++;
      if (hl_we != 0) bad++;
      n++;
      cyc();
    end
    check({tag, "_stall_cycles"}, 64'(n), 64'(exp_stall));
    check({tag, "_tvalid_sel"}, {62'd0, saw_s, saw_u}, {62'd0, mudi[2], mudi[3]});
    check({tag, "_tvalid_cycles"}, 64'(tv_n), 64'(hold + 1));
    check({tag, "_stable"}, 64'(bad), 64'd0);
    op_fire = 1;
    #1;
    check({tag, "_we"}, {62'd0, hl_we}, 64'd3);
    check({tag, "_hi"}, {32'd0, hi_wdata}, {32'd0, ehi});
    check({tag, "_lo"}, {32'd0, lo_wdata}, {32'd0, elo});
    cyc();
    op_valid = 0; op_fire = 0; op_mudi = 0;
    #1;
    check({tag, "_handshakes"}, 64'(hs_cnt - h0), 64'd1);
    check({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int bad, d0;
    repeat (2) cyc();
    reset = 0;
    #1;
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_tvalid", {62'd0, div_s_tvalid, div_u_tvalid}, 64'd0);
    check("rst_we", {62'd0, hl_we}, 64'd0);
    check("rst_wdata", {hi_wdata, lo_wdata}, 64'd0);

    run_div("div", 4'b0100, 32'd100, 32'd7, 0, 10, 32'd2, 32'd14);
    run_div("divu", 4'b1000, 32'hFFFF_FFFF, 32'd2, 0, 10, 32'd1, 32'h7FFF_FFFF);
    run_div("tready_hold", 4'b0100, 32'd20, 32'd3, 3, 13, 32'd2, 32'd6);

    // flush in WAIT, then a new DIV must wait for the stale result to drain
    op_valid = 1; op_mudi = 4'b0100; src1 = 32'd50; src2 = 32'd5;
    div_s_tready = 1; div_u_tready = 1;
    repeat (3) begin
      #1;
      cyc();
    end
    flush = 1;
    #1;
    check("flush_we", {62'd0, hl_we}, 64'd0);
    check("flush_stall", {63'd0, stall}, 64'd0);
    cyc();
    flush = 0;
    #1;
    check("drain_busy", {63'd0, busy}, 64'd1);
    run_div("div_after_drain", 4'b0100, 32'hFFFF_FFFA, 32'd4, 0, 16, 32'hFFFF_FFFE, 32'hFFFF_FFFF);

    op_valid = 1; op_mudi = 4'b0001; src1 = 32'hFFFF_FFFF; src2 = 32'd2;
    prod = 64'hFFFF_FFFF_FFFF_FFFE; op_fire = 1;
    #1;
    check("mult_stall", {63'd0, stall}, 64'd0);
    check("mult_we", {62'd0, hl_we}, 64'd3);
    check("mult_hi", {32'd0, hi_wdata}, 64'hFFFF_FFFF);
    check("mult_lo", {32'd0, lo_wdata}, 64'hFFFF_FFFE);
    flush = 1;
    #1;
    check("mult_flush_we", {62'd0, hl_we}, 64'd0);
    flush = 0; op_valid = 0; op_fire = 0; op_mudi = 0;
    cyc();

    // reset in WAIT; the late result must not revive the sequencer
    op_valid = 1; op_mudi = 4'b0100; src1 = 32'd9; src2 = 32'd2;
    repeat (2) begin
      #1;
      cyc();
    end
    #1;
    check("wait_busy", {63'd0, busy}, 64'd1);
    reset = 1; op_valid = 0; op_mudi = 0;
    cyc();
    reset = 0;
    #1;
    check("rst_mid_idle", {63'd0, busy}, 64'd0);
    bad = 0;
    d0 = dv_cnt;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (busy || hl_we != 0 || div_s_tvalid || div_u_tvalid) bad++;
      cyc();
    end
    check("stale_ignored", 64'(bad), 64'd0);
    check("stale_seen", {63'd0, dv_cnt > d0}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
